friscv_cache_refill_ctrl: RTL and testbench
===========================================

Name: friscv_cache_refill_ctrl

Overview:
Sequences cache-line refills after a cache miss.
- Accepts one miss request at a time from the block fetcher.
- Issues a single-beat AXI4 read to central memory; one beat is one cache block, since AXI_DATA_W equals the block width.
- Writes the returned line into the cache and drives cache_writing so the fetcher can replay the missed access.
- Sits between the block fetcher's miss path and the AXI4 master to central memory.

Parameters:
AXI_ADDR_W, 32, AXI4 address width
AXI_ID_W, 8, AXI4 ID width
AXI_DATA_W, 128, AXI4 data width (= cache block width)
ADDR_LSB_W, $clog2(AXI_DATA_W/8), low address bits zeroed to align on a block

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
srst  in  1  synchronous reset, active high
flush  in  1  abandon current refill (FENCE.i / request flush)
miss_valid  in  1  miss request valid
miss_ready  out  1  miss request accepted
miss_addr  in  AXI_ADDR_W  missed address
miss_id  in  AXI_ID_W  missed request ID
miss_prot  in  3  missed request protection
mem_arvalid  out  1  AXI4 read address valid
mem_arready  in  1  AXI4 read address ready
mem_araddr  out  AXI_ADDR_W  block-aligned read address
mem_arid  out  AXI_ID_W  read ID
mem_arprot  out  3  read protection
mem_rvalid  in  1  AXI4 read data valid
mem_rready  out  1  AXI4 read data ready
mem_rid  in  AXI_ID_W  read data ID
mem_rresp  in  2  read response
mem_rdata  in  AXI_DATA_W  read line
cache_wen  out  1  cache line write strobe
cache_waddr  out  AXI_ADDR_W  block-aligned write address
cache_wdata  out  AXI_DATA_W  line data
cache_writing  out  1  refill write phase in progress
pending_rd  out  1  refill outstanding (miss accepted, line not yet written)
rd_error  out  1  one-cycle pulse on non-OKAY rresp

Behaviour:
- Reset, async or srst: FSM=IDLE; all outputs 0; internal addr/id/prot registers 0; drop counter 0.
- FSM states:
  - IDLE: miss_ready=1. On miss_valid && !flush, latch {addr with low ADDR_LSB_W bits cleared, id, prot}, go to ARREQ, pending_rd<=1.
  - ARREQ: mem_arvalid=1 with latched values; stable until mem_arready. On handshake go to RWAIT.
  - RWAIT: mem_rready=1. On mem_rvalid with mem_rid==latched id, register rdata and go to WRITE. A non-matching rid is accepted and discarded.
  - WRITE: cache_wen=1 and cache_writing=1 for exactly 1 cycle. Next state HOLD.
  - HOLD: cache_writing=1 for 1 more cycle so the fetcher observes it across its LOAD->FETCH transition. pending_rd cleared; return to IDLE.
- Latency: miss accept to cache_wen is 3 cycles, assuming arready and rvalid are each returned on the first cycle offered.
- miss_ready is high only in IDLE; a miss presented elsewhere waits.
- rresp!=0: line still written; rd_error pulses for 1 cycle in WRITE.
- Flush handling:
  - IDLE/HOLD: no effect beyond blocking new acceptance that cycle.
  - ARREQ before handshake: arvalid must not be retracted. Complete the AR handshake, then increment the drop counter and return to IDLE.
  - ARREQ with handshake in the same cycle, or RWAIT: increment the drop counter; go to IDLE.
  - WRITE: write completes; then IDLE.
  - pending_rd cleared on flush.
- Drop counter: width $clog2(4)+1.
  - While nonzero, mem_rready=1 in every state; each R beat decrements it and is discarded.
  - A new miss is not accepted until the counter is 0, to avoid confusing stale data with the new ID.
  - Saturates at 4; miss_ready=0 while saturated.
- Simultaneous events:
  - flush and srst together: srst wins.
  - flush and miss_valid in IDLE: the miss is not accepted.

Optional Feature:
Macro: CACHE_REFILL_DEDUP_EN
- Defined: hold a "last filled block" register (valid bit + block address), cleared on flush/reset.
  - A miss whose block address matches it, while that line was written in the last 2 cycles, is accepted in IDLE.
  - No AXI read is issued for it; the controller goes straight to HOLD with cache_writing=1 for 1 cycle.
- Undefined: every accepted miss issues an AXI read.

Test Plan:
- Basic refill: miss_addr=0x1004, id=3, arready/rvalid immediate, rresp=0 -> mem_araddr=0x1000, mem_arid=3; cache_wen 3 cycles after accept with waddr=0x1000; cache_writing high 2 cycles; pending_rd falls with HOLD.
- Backpressure: arready low 5 cycles -> mem_arvalid and mem_araddr stable for all 6 cycles; miss_ready=0 throughout.
- Flush in RWAIT: flush after AR handshake, stale R arrives 4 cycles later -> no cache_wen; new miss 0x2000 accepted only after the stale beat is consumed; second refill writes 0x2000.
- Error response: rresp=2'b10 -> cache_wen asserted, rd_error one-cycle pulse coinciding with WRITE.
- Async reset mid-RWAIT: aresetn low -> all outputs 0 immediately; after release miss_ready=1, no spurious write.
- Dedup (CACHE_REFILL_DEDUP_EN): two misses to 0x3000 and 0x3008 back-to-back -> exactly one AR; second yields cache_writing 1 cycle, no cache_wen.

Source files
------------

// File: rtl/friscv_cache_refill_ctrl.sv
// Cache-line refill sequencer: takes one miss at a time from the block fetcher,
// issues a single-beat AXI4 read for the whole block, writes the returned line
// into the cache and holds cache_writing long enough for the fetcher to replay.
// Flushed refills are tracked by a drop counter so their late R beats are
// swallowed instead of being mistaken for data of a newer request.
//
// Optional feature, enabled by defining CACHE_REFILL_DEDUP_EN:
//   a "last filled block" register lets a miss to a block written in the last
//   two cycles skip the AXI read and go straight to the HOLD phase.
//
// All outputs are registered; each one is computed from the next-state values
// so that it lines up with the state it belongs to.

module friscv_cache_refill_ctrl #(
    parameter int unsigned AXI_ADDR_W = 32,
    parameter int unsigned AXI_ID_W   = 8,
    parameter int unsigned AXI_DATA_W = 128,
    parameter int unsigned ADDR_LSB_W = $clog2(AXI_DATA_W / 8)
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  srst,
    input  logic                  flush,
    // miss request from the block fetcher
    input  logic                  miss_valid,
    output logic                  miss_ready,
    input  logic [AXI_ADDR_W-1:0] miss_addr,
    input  logic [AXI_ID_W-1:0]   miss_id,
    input  logic [2:0]            miss_prot,
    // AXI4 read address channel
    output logic                  mem_arvalid,
    input  logic                  mem_arready,
    output logic [AXI_ADDR_W-1:0] mem_araddr,
    output logic [AXI_ID_W-1:0]   mem_arid,
    output logic [2:0]            mem_arprot,
    // AXI4 read data channel
    input  logic                  mem_rvalid,
    output logic                  mem_rready,
    input  logic [AXI_ID_W-1:0]   mem_rid,
    input  logic [1:0]            mem_rresp,
    input  logic [AXI_DATA_W-1:0] mem_rdata,
    // cache write port
    output logic                  cache_wen,
    output logic [AXI_ADDR_W-1:0] cache_waddr,
    output logic [AXI_DATA_W-1:0] cache_wdata,
    output logic                  cache_writing,
    // status
    output logic                  pending_rd,
    output logic                  rd_error
);

    localparam int unsigned DROP_W = $clog2(4) + 1;
    localparam logic [DROP_W-1:0] DROP_MAX = DROP_W'(4);
    localparam logic [AXI_ADDR_W-1:0] LSB_MASK =
        {{(AXI_ADDR_W - ADDR_LSB_W){1'b0}}, {ADDR_LSB_W{1'b1}}};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARREQ = 3'd1,
        RWAIT = 3'd2,
        WRITE = 3'd3,
        HOLD  = 3'd4
    } state_t;

    // FSM and request context
    state_t                state_q, state_d;
    logic [AXI_ADDR_W-1:0] addr_q, addr_d;
    logic [AXI_ID_W-1:0]   id_q, id_d;
    logic [2:0]            prot_q, prot_d;
    logic [AXI_DATA_W-1:0] data_q, data_d;
    logic                  abort_q, abort_d;
    logic [DROP_W-1:0]     drop_q, drop_d;

    // registered outputs
    logic miss_ready_q, miss_ready_d;
    logic arvalid_q, arvalid_d;
    logic rready_q, rready_d;
    logic wen_q, wen_d;
    logic writing_q, writing_d;
    logic pending_q, pending_d;
    logic rd_error_q, rd_error_d;

    // handshakes and helpers
    logic                  miss_fire;
    logic                  ar_fire;
    logic                  r_fire;
    logic                  id_match;
    logic                  drop_inc;
    logic                  drop_dec;
    logic                  dedup_hit;
    logic [AXI_ADDR_W-1:0] miss_blk;

    assign miss_blk  = miss_addr & ~LSB_MASK;
    assign miss_fire = miss_valid && miss_ready_q && !flush;
    assign ar_fire   = arvalid_q && mem_arready;
    assign r_fire    = mem_rvalid && rready_q;
    assign id_match  = (mem_rid == id_q);
    // R beats arriving while stale reads are outstanding belong to them
    assign drop_dec  = r_fire && (drop_q != '0);

`ifdef CACHE_REFILL_DEDUP_EN
    logic                  lf_valid_q, lf_valid_d;
    logic [AXI_ADDR_W-1:0] lf_addr_q, lf_addr_d;
    logic [1:0]            lf_age_q, lf_age_d;

    // A miss to the block written one or two cycles ago is already in the cache
    assign dedup_hit = lf_valid_q && (lf_age_q <= 2'd1) && (lf_addr_q == miss_blk);

    // Track the most recently written block and how long ago it was written
    always_comb begin
        lf_valid_d = lf_valid_q;
        lf_addr_d  = lf_addr_q;
        lf_age_d   = lf_age_q;
        if (srst || flush) begin
            lf_valid_d = 1'b0;
            lf_addr_d  = '0;
            lf_age_d   = '0;
        end else if (state_q == WRITE) begin
            lf_valid_d = 1'b1;
            lf_addr_d  = addr_q;
            lf_age_d   = '0;
        end else if (lf_age_q != 2'd3) begin
            lf_age_d = lf_age_q + 2'd1;
        end
    end

    // Last-filled-block register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            lf_valid_q <= 1'b0;
            lf_addr_q  <= '0;
            lf_age_q   <= '0;
        end else begin
            lf_valid_q <= lf_valid_d;
            lf_addr_q  <= lf_addr_d;
            lf_age_q   <= lf_age_d;
        end
    end
`else
    assign dedup_hit = 1'b0;
`endif

    // Next-state, context and registered-output computation
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        id_d       = id_q;
        prot_d     = prot_q;
        data_d     = data_q;
        abort_d    = abort_q;
        drop_d     = drop_q;
        drop_inc   = 1'b0;
        rd_error_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (miss_fire) begin
                    addr_d  = miss_blk;
                    id_d    = miss_id;
                    prot_d  = miss_prot;
                    abort_d = 1'b0;
                    state_d = dedup_hit ? HOLD : ARREQ;
                end
            end
            ARREQ: begin
                // arvalid is never retracted; a flush only marks the read as stale
                if (ar_fire) begin
                    if (flush || abort_q) begin
                        drop_inc = 1'b1;
                        abort_d  = 1'b0;
                        state_d  = IDLE;
                    end else begin
                        state_d = RWAIT;
                    end
                end else if (flush) begin
                    abort_d = 1'b1;
                end
            end
            RWAIT: begin
                if (flush) begin
                    // a matching beat consumed this very cycle leaves nothing outstanding
                    drop_inc = !(r_fire && id_match);
                    state_d  = IDLE;
                end else if (r_fire && id_match) begin
                    data_d     = mem_rdata;
                    rd_error_d = (mem_rresp != 2'b00);
                    state_d    = WRITE;
                end
            end
            WRITE: begin
                state_d = flush ? IDLE : HOLD;
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (drop_inc && !drop_dec) begin
            drop_d = (drop_q == DROP_MAX) ? drop_q : drop_q + DROP_W'(1);
        end else if (drop_dec && !drop_inc) begin
            drop_d = drop_q - DROP_W'(1);
        end

        miss_ready_d = (state_d == IDLE) && (drop_d == '0);
        arvalid_d    = (state_d == ARREQ);
        rready_d     = (state_d == RWAIT) || (drop_d != '0);
        wen_d        = (state_d == WRITE);
        writing_d    = (state_d == WRITE) || (state_d == HOLD);
        pending_d    = ((state_d == ARREQ) || (state_d == RWAIT) || (state_d == WRITE))
                       && !abort_d;

        // synchronous reset overrides everything, flush included
        if (srst) begin
            state_d      = IDLE;
            addr_d       = '0;
            id_d         = '0;
            prot_d       = '0;
            data_d       = '0;
            abort_d      = 1'b0;
            drop_d       = '0;
            rd_error_d   = 1'b0;
            miss_ready_d = 1'b0;
            arvalid_d    = 1'b0;
            rready_d     = 1'b0;
            wen_d        = 1'b0;
            writing_d    = 1'b0;
            pending_d    = 1'b0;
        end
    end

    // State, context and output registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= IDLE;
            addr_q       <= '0;
            id_q         <= '0;
            prot_q       <= '0;
            data_q       <= '0;
            abort_q      <= 1'b0;
            drop_q       <= '0;
            miss_ready_q <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            wen_q        <= 1'b0;
            writing_q    <= 1'b0;
            pending_q    <= 1'b0;
            rd_error_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            id_q         <= id_d;
            prot_q       <= prot_d;
            data_q       <= data_d;
            abort_q      <= abort_d;
            drop_q       <= drop_d;
            miss_ready_q <= miss_ready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            wen_q        <= wen_d;
            writing_q    <= writing_d;
            pending_q    <= pending_d;
            rd_error_q   <= rd_error_d;
        end
    end

    assign miss_ready    = miss_ready_q;
    assign mem_arvalid   = arvalid_q;
    assign mem_araddr    = addr_q;
    assign mem_arid      = id_q;
    assign mem_arprot    = prot_q;
    assign mem_rready    = rready_q;
    assign cache_wen     = wen_q;
    assign cache_waddr   = addr_q;
    assign cache_wdata   = data_q;
    assign cache_writing = writing_q;
    assign pending_rd    = pending_q;
    assign rd_error      = rd_error_q;

endmodule

// File: tb/tb_friscv_cache_refill_ctrl.sv
// Directed bench for friscv_cache_refill_ctrl with a transaction scoreboard:
// expected AR requests and cache writes are queued from the refill rules and
// checked by a compare process on every cycle they can occur.
module tb_friscv_cache_refill_ctrl;

    localparam int unsigned AW = 32;
    localparam int unsigned IW = 8;
    localparam int unsigned DW = 128;

    logic          aclk, aresetn, srst, flush;
    logic          miss_valid, miss_ready;
    logic [AW-1:0] miss_addr;
    logic [IW-1:0] miss_id;
    logic [2:0]    miss_prot;
    logic          mem_arvalid, mem_arready;
    logic [AW-1:0] mem_araddr;
    logic [IW-1:0] mem_arid;
    logic [2:0]    mem_arprot;
    logic          mem_rvalid, mem_rready;
    logic [IW-1:0] mem_rid;
    logic [1:0]    mem_rresp;
    logic [DW-1:0] mem_rdata;
    logic          cache_wen;
    logic [AW-1:0] cache_waddr;
    logic [DW-1:0] cache_wdata;
    logic          cache_writing, pending_rd, rd_error;

    friscv_cache_refill_ctrl dut (
        .aclk(aclk), .aresetn(aresetn), .srst(srst), .flush(flush),
        .miss_valid(miss_valid), .miss_ready(miss_ready), .miss_addr(miss_addr),
        .miss_id(miss_id), .miss_prot(miss_prot),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_arid(mem_arid), .mem_arprot(mem_arprot),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready), .mem_rid(mem_rid),
        .mem_rresp(mem_rresp), .mem_rdata(mem_rdata),
        .cache_wen(cache_wen), .cache_waddr(cache_waddr), .cache_wdata(cache_wdata),
        .cache_writing(cache_writing), .pending_rd(pending_rd), .rd_error(rd_error)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected-transaction model
    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] id;
        logic [2:0]    prot;
    } ar_exp_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          err;
    } wr_exp_t;

    ar_exp_t exp_ar[$];
    wr_exp_t exp_wr[$];

    // block address: round down to a multiple of the line size in bytes
    function automatic logic [AW-1:0] blk(input logic [AW-1:0] a);
        return a - (a % AW'(DW / 8));
    endfunction

    task automatic expect_ar(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [2:0] p);
        ar_exp_t e;
        e.addr = blk(a); e.id = id; e.prot = p;
        exp_ar.push_back(e);
    endtask

    task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic err);
        wr_exp_t e;
        e.addr = blk(a); e.data = d; e.err = err;
        exp_wr.push_back(e);
    endtask

    // Compare process: every AR handshake and every cache write against the model
    always @(negedge aclk) begin
        if (aresetn) begin
            if (mem_arvalid && mem_arready) begin
                chk("sb_ar_expected", 128'(exp_ar.size() != 0), 128'(1));
                if (exp_ar.size() != 0) begin
                    ar_exp_t ea;
                    ea = exp_ar.pop_front();
                    chk("sb_araddr", 128'(mem_araddr), 128'(ea.addr));
                    chk("sb_arid", 128'(mem_arid), 128'(ea.id));
                    chk("sb_arprot", 128'(mem_arprot), 128'(ea.prot));
                end
            end
            if (cache_wen) begin
                chk("sb_wr_expected", 128'(exp_wr.size() != 0), 128'(1));
                chk("sb_wen_writing", 128'(cache_writing), 128'(1));
                if (exp_wr.size() != 0) begin
                    wr_exp_t ew;
                    ew = exp_wr.pop_front();
                    chk("sb_waddr", 128'(cache_waddr), 128'(ew.addr));
                    chk("sb_wdata", 128'(cache_wdata), 128'(ew.data));
                    chk("sb_rd_error", 128'(rd_error), 128'(ew.err));
                end
            end else begin
                chk("sb_rd_error_quiet", 128'(rd_error), 128'(0));
            end
        end
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Present a miss, wait (bounded) for miss_ready, and return in the cycle after acceptance
    task automatic issue_miss(input logic [AW-1:0] a, input logic [IW-1:0] id, input logic [2:0] p);
        int n;
        n = 0;
        miss_valid = 1'b1; miss_addr = a; miss_id = id; miss_prot = p;
        while (miss_ready !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        chk("miss_accept_wait", 128'(miss_ready), 128'(1));
        step();
        miss_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_ctrl"}, 128'({miss_ready, mem_arvalid, mem_rready, cache_wen,
                                   cache_writing, pending_rd, rd_error}), 128'(0));
        chk({name, "_addr"}, 128'({mem_araddr, cache_waddr, mem_arid, mem_arprot}), 128'(0));
        chk({name, "_data"}, 128'(cache_wdata), 128'(0));
    endtask

    localparam logic [DW-1:0] D1 = {4{32'hA5A5_0001}};
    localparam logic [DW-1:0] D2 = {4{32'h1234_5678}};
    localparam logic [DW-1:0] D3 = {4{32'hCAFE_0003}};
    localparam logic [DW-1:0] D4 = {4{32'hDEAD_0004}};
    localparam logic [DW-1:0] DJ = {4{32'hBAD0_BAD0}};

    initial begin
        aresetn = 1'b0; srst = 1'b0; flush = 1'b0;
        miss_valid = 1'b0; miss_addr = '0; miss_id = '0; miss_prot = '0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rid = '0; mem_rresp = '0; mem_rdata = '0;

        // reset state
        repeat (2) step();
        chk_all_zero("reset");
        aresetn = 1'b1;
        step();
        chk("idle_miss_ready", 128'(miss_ready), 128'(1));
        chk("idle_rready", 128'(mem_rready), 128'(0));

        // basic refill, immediate handshakes
        mem_arready = 1'b1;
        expect_ar(32'h1004, 8'd3, 3'b010);
        expect_wr(32'h1004, D1, 1'b0);
        issue_miss(32'h1004, 8'd3, 3'b010);
        chk("t1_arvalid", 128'(mem_arvalid), 128'(1));
        chk("t1_araddr", 128'(mem_araddr), 128'(32'h1000));
        chk("t1_arid", 128'(mem_arid), 128'(3));
        chk("t1_miss_ready", 128'(miss_ready), 128'(0));
        chk("t1_pending", 128'(pending_rd), 128'(1));
        step();
        chk("t1_rready", 128'(mem_rready), 128'(1));
        chk("t1_arvalid_low", 128'(mem_arvalid), 128'(0));
        mem_rvalid = 1'b1; mem_rid = 8'd3; mem_rresp = 2'b00; mem_rdata = D1;
        step();
        mem_rvalid = 1'b0;
        chk("t1_wen", 128'(cache_wen), 128'(1));
        chk("t1_writing", 128'(cache_writing), 128'(1));
        chk("t1_waddr", 128'(cache_waddr), 128'(32'h1000));
        chk("t1_wdata", 128'(cache_wdata), 128'(D1));
        chk("t1_pending_write", 128'(pending_rd), 128'(1));
        step();
        chk("t1_hold_wen", 128'(cache_wen), 128'(0));
        chk("t1_hold_writing", 128'(cache_writing), 128'(1));
        chk("t1_hold_pending", 128'(pending_rd), 128'(0));
        step();
        chk("t1_done_writing", 128'(cache_writing), 128'(0));
        chk("t1_done_ready", 128'(miss_ready), 128'(1));

        // AR backpressure, a competing miss waits, a foreign R beat is discarded
        mem_arready = 1'b0;
        expect_ar(32'h204C, 8'd5, 3'b000);
        expect_wr(32'h204C, D2, 1'b0);
        issue_miss(32'h204C, 8'd5, 3'b000);
        miss_valid = 1'b1; miss_addr = 32'h9000; miss_id = 8'd9;
        for (int i = 0; i < 5; i++) begin
            chk("t2_arvalid", 128'(mem_arvalid), 128'(1));
            chk("t2_araddr", 128'(mem_araddr), 128'(32'h2040));
            chk("t2_miss_ready", 128'(miss_ready), 128'(0));
            step();
        end
        chk("t2_arvalid_last", 128'(mem_arvalid), 128'(1));
        chk("t2_araddr_last", 128'(mem_araddr), 128'(32'h2040));
        miss_valid = 1'b0;
        mem_arready = 1'b1;
        step();
        chk("t2_ar_done", 128'(mem_arvalid), 128'(0));
        mem_rvalid = 1'b1; mem_rid = 8'd9; mem_rdata = DJ;
        step();
        chk("t2_foreign_no_wen", 128'(cache_wen), 128'(0));
        chk("t2_still_rready", 128'(mem_rready), 128'(1));
        mem_rid = 8'd5; mem_rdata = D2;
        step();
        mem_rvalid = 1'b0;
        chk("t2_wen", 128'(cache_wen), 128'(1));
        chk("t2_wdata", 128'(cache_wdata), 128'(D2));
        repeat (2) step();
        chk("t2_idle", 128'(miss_ready), 128'(1));

        // flush in RWAIT; stale beat four cycles later; next miss waits for it
        mem_arready = 1'b1;
        expect_ar(32'h1100, 8'd7, 3'b000);
        expect_ar(32'h2000, 8'd8, 3'b000);
        expect_wr(32'h2000, D3, 1'b0);
        issue_miss(32'h1100, 8'd7, 3'b000);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t3_pending_cleared", 128'(pending_rd), 128'(0));
        chk("t3_ready_blocked", 128'(miss_ready), 128'(0));
        chk("t3_drain_rready", 128'(mem_rready), 128'(1));
        miss_valid = 1'b1; miss_addr = 32'h2000; miss_id = 8'd8; miss_prot = 3'b000;
        step();
        chk("t3_wait1", 128'(miss_ready), 128'(0));
        step();
        chk("t3_wait2", 128'(miss_ready), 128'(0));
        step();
        chk("t3_wait3", 128'(miss_ready), 128'(0));
        mem_rvalid = 1'b1; mem_rid = 8'd7; mem_rdata = DJ;
        step();
        mem_rvalid = 1'b0;
        chk("t3_ready_after_drain", 128'(miss_ready), 128'(1));
        chk("t3_rready_off", 128'(mem_rready), 128'(0));
        step();
        miss_valid = 1'b0;
        chk("t3_new_araddr", 128'(mem_araddr), 128'(32'h2000));
        step();
        mem_rvalid = 1'b1; mem_rid = 8'd8; mem_rdata = D3;
        step();
        mem_rvalid = 1'b0;
        chk("t3_wen", 128'(cache_wen), 128'(1));
        chk("t3_waddr", 128'(cache_waddr), 128'(32'h2000));
        repeat (2) step();

        // error response: line still written, rd_error pulses with the write
        expect_ar(32'h401F, 8'd1, 3'b001);
        expect_wr(32'h401F, D4, 1'b1);
        issue_miss(32'h401F, 8'd1, 3'b001);
        step();
        mem_rvalid = 1'b1; mem_rid = 8'd1; mem_rresp = 2'b10; mem_rdata = D4;
        step();
        mem_rvalid = 1'b0; mem_rresp = 2'b00;
        chk("t4_wen", 128'(cache_wen), 128'(1));
        chk("t4_rd_error", 128'(rd_error), 128'(1));
        chk("t4_waddr", 128'(cache_waddr), 128'(32'h4010));
        step();
        chk("t4_rd_error_pulse", 128'(rd_error), 128'(0));
        step();

        // flush in ARREQ before the handshake: AR completes, then one beat is dropped
        mem_arready = 1'b0;
        expect_ar(32'h6000, 8'd4, 3'b000);
        issue_miss(32'h6000, 8'd4, 3'b000);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("t5_arvalid_kept", 128'(mem_arvalid), 128'(1));
        chk("t5_pending_cleared", 128'(pending_rd), 128'(0));
        mem_arready = 1'b1;
        step();
        chk("t5_ar_done", 128'(mem_arvalid), 128'(0));
        chk("t5_ready_blocked", 128'(miss_ready), 128'(0));
        chk("t5_drain_rready", 128'(mem_rready), 128'(1));
        mem_rvalid = 1'b1; mem_rid = 8'd4; mem_rdata = DJ;
        step();
        mem_rvalid = 1'b0;
        chk("t5_ready_after_drain", 128'(miss_ready), 128'(1));

        // async reset in RWAIT
        expect_ar(32'h5000, 8'd2, 3'b000);
        issue_miss(32'h5000, 8'd2, 3'b000);
        step();
        chk("t6_rwait", 128'(mem_rready), 128'(1));
        #1 aresetn = 1'b0;
        #1 chk_all_zero("t6_async");
        mem_rvalid = 1'b1; mem_rid = 8'd2; mem_rdata = DJ;
        repeat (2) step();
        mem_rvalid = 1'b0;
        aresetn = 1'b1;
        step();
        chk("t6_ready", 128'(miss_ready), 128'(1));
        chk("t6_no_wen", 128'(cache_wen), 128'(0));
        step();
        chk("t6_no_writing", 128'(cache_writing), 128'(0));

        // srst together with flush in ARREQ: reset wins, no dropped read recorded
        mem_arready = 1'b0;
        issue_miss(32'h7000, 8'd6, 3'b000);
        srst = 1'b1; flush = 1'b1;
        step();
        srst = 1'b0; flush = 1'b0;
        chk_all_zero("t7_srst");
        step();
        chk("t7_ready", 128'(miss_ready), 128'(1));
        chk("t7_no_drain", 128'(mem_rready), 128'(0));

`ifdef CACHE_REFILL_DEDUP_EN
        // back-to-back misses to the same block: one AR, second only holds cache_writing
        mem_arready = 1'b1;
        expect_ar(32'h3000, 8'd1, 3'b000);
        expect_wr(32'h3000, D1, 1'b0);
        issue_miss(32'h3000, 8'd1, 3'b000);
        step();
        mem_rvalid = 1'b1; mem_rid = 8'd1; mem_rdata = D1;
        step();
        mem_rvalid = 1'b0;
        miss_valid = 1'b1; miss_addr = 32'h3008; miss_id = 8'd2;
        step();
        step();
        chk("t8_ready", 128'(miss_ready), 128'(1));
        step();
        miss_valid = 1'b0;
        chk("t8_writing", 128'(cache_writing), 128'(1));
        chk("t8_no_wen", 128'(cache_wen), 128'(0));
        chk("t8_no_ar", 128'(mem_arvalid), 128'(0));
        step();
        chk("t8_writing_off", 128'(cache_writing), 128'(0));
`endif

        repeat (3) step();
        chk("ar_queue_empty", 128'(exp_ar.size()), 128'(0));
        chk("wr_queue_empty", 128'(exp_wr.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
